// File: rtl/adc128s022_responder_pkg.sv
// rtl/adc128s022_responder_pkg.sv - frame constants and types shared by the responder and its controller
package adc128s022_responder_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = 4;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_W          = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [4:0]        cnt_t;

endpackage

// File: rtl/adc128s022_responder_sync_edge_detect.sv
// rtl/adc128s022_responder_sync_edge_detect.sv - multi-flop synchronizer with registered edge detect
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// rtl/adc128s022_responder.sv - ADC128S022 serial responder returning values from a parallel channel bus
module adc128s022_responder
  import adc128s022_responder_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     adc_cs_n,
  input  logic                     adc_sck,
  input  logic                     din,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     dout,
  output logic                     dout_oe,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [ADDR_W-1:0]        cur_addr
);

  localparam cnt_t CNT_LAST    = cnt_t'(FRAME_BITS);
  localparam cnt_t CNT_ADDR_LO = cnt_t'(ADDR_FIRST_EDGE);
  localparam cnt_t CNT_ADDR_HI = cnt_t'(ADDR_FIRST_EDGE + ADDR_W - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic din_level, din_rise, din_fall;
  logic unused_edges;

  logic [DATA_W-1:0]      ch_arr [NUM_CH];
  logic [FRAME_BITS-1:0]  sreg;
  logic [FRAME_BITS-1:0]  load_word;
  cnt_t                   bit_cnt;
  cnt_t                   cnt_inc;
  addr_t                  next_addr;
  logic [SYNC_STAGES-1:0] settle;
  logic                   armed;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk_50), .rst(rst), .d(adc_cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .clk(clk_50), .rst(rst), .d(adc_sck), .level(sck_level), .rise(sck_rise), .fall(sck_fall));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din (
    .clk(clk_50), .rst(rst), .d(din), .level(din_level), .rise(din_rise), .fall(din_fall));

  assign unused_edges = &{1'b0, sck_level, din_rise, din_fall};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  assign load_word = FRAME_BITS'({{LEAD_ZEROS{1'b0}}, ch_arr[cur_addr]});
  assign cnt_inc   = bit_cnt + 5'd1;
  assign dout      = sreg[FRAME_BITS-1];

  always_ff @(posedge clk_50) begin
    if (rst) begin
      bit_cnt    <= '0;
      sreg       <= '0;
      next_addr  <= '0;
      cur_addr   <= '0;
      dout_oe    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      settle     <= '0;
      armed      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      settle     <= {settle[SYNC_STAGES-2:0], 1'b1};
      // A frame may only start once CS has been seen high through a settled synchronizer,
      // so CS already low when reset is released does not open a frame.
      if (settle[SYNC_STAGES-1] && cs_level) armed <= 1'b1;

      if (cs_fall && armed) begin
        bit_cnt   <= '0;
        dout_oe   <= 1'b1;
        sreg      <= load_word;
        next_addr <= '0;
      end else if (cs_rise) begin
        if (dout_oe && bit_cnt != '0 && bit_cnt != CNT_LAST) frame_err <= 1'b1;
        dout_oe   <= 1'b0;
        sreg      <= '0;
        next_addr <= '0;
      end else if (dout_oe && !cs_level) begin
        if (sck_rise && bit_cnt != CNT_LAST) begin
          bit_cnt <= cnt_inc;
          if (cnt_inc >= CNT_ADDR_LO && cnt_inc <= CNT_ADDR_HI)
            next_addr <= {next_addr[ADDR_W-2:0], din_level};
          if (cnt_inc == CNT_LAST) begin
            frame_done <= 1'b1;
            cur_addr   <= next_addr;
          end
        end else if (sck_fall) begin
          // The falling edge after the last rising edge starts the next back-to-back frame.
          if (bit_cnt == CNT_LAST) begin
            sreg      <= load_word;
            bit_cnt   <= '0;
            next_addr <= '0;
          end else if (bit_cnt != '0) begin
            sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc128s022_responder.sv
// tb/tb_adc128s022_responder.sv - scoreboard bench for adc128s022_responder
module tb_adc128s022_responder;

  localparam int H = 8;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic        adc_cs_n = 1'b1;
  logic        adc_sck = 1'b1;
  logic        din = 1'b0;
  logic [95:0] ch_data = '0;
  logic        dout, dout_oe, frame_done, frame_err;
  logic [2:0]  cur_addr;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cap = '0;
  logic [2:0]  m_addr = '0;
  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;

  always #10 clk_50 = ~clk_50;

  adc128s022_responder dut (
    .clk_50(clk_50), .rst(rst), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .din(din),
    .ch_data(ch_data), .dout(dout), .dout_oe(dout_oe), .frame_done(frame_done),
    .frame_err(frame_err), .cur_addr(cur_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Serial capture: the controller samples dout on SCLK rising edges.
  initial forever begin
    @(posedge adc_sck);
    if (!adc_cs_n) cap = {cap[14:0], dout};
  end

  initial forever begin
    exp_t e;
    @(negedge clk_50);
    if (frame_err) err_cnt++;
    if (frame_done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("frame_word", cap, e.word);
        check("addr_after", cur_addr, e.addr);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_50);
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_data[k*12 +: 12] = v;
  endtask

  task automatic sck_cycle(input logic d);
    adc_sck = 1'b0;
    din = d;
    wait_clk(H);
    adc_sck = 1'b1;
    wait_clk(H);
  endtask

  // SCLK cycles first..last of a frame; address bits ride on cycles 3..5, MSB first.
  task automatic frame_bits(input logic [2:0] addr, input int first, input int last);
    logic d;
    for (int k = first; k <= last; k++) begin
      d = 1'($urandom_range(0, 1));
      if (k >= 3 && k <= 5) d = addr[5-k];
      sck_cycle(d);
    end
  endtask

  // Reference: a full frame returns the channel chosen by the previous completed frame.
  task automatic expect_frame(input logic [2:0] addr);
    exp_t e;
    e.word = {4'b0000, ch_data[m_addr*12 +: 12]};
    e.addr = addr;
    exp_q.push_back(e);
    m_addr = addr;
    exp_done++;
  endtask

  task automatic cs_low();
    adc_cs_n = 1'b0;
    wait_clk(H);
    check("oe_on", dout_oe, 1);
  endtask

  task automatic cs_high();
    adc_cs_n = 1'b1;
    wait_clk(H);
    check("oe_off", dout_oe, 0);
    check("dout_idle", dout, 0);
  endtask

  task automatic run_frame(input logic [2:0] addr);
    cs_low();
    expect_frame(addr);
    frame_bits(addr, 1, 16);
    cs_high();
  endtask

  task automatic run_pair(input logic [2:0] a1, input logic [2:0] a2);
    cs_low();
    expect_frame(a1);
    frame_bits(a1, 1, 16);
    expect_frame(a2);
    frame_bits(a2, 1, 16);
    cs_high();
  endtask

  task automatic run_abort(input logic [2:0] addr, input int n);
    cs_low();
    frame_bits(addr, 1, n);
    cs_high();
    exp_err++;
  endtask

  initial begin
    int sel;
    logic [2:0] a1, a2;

    wait_clk(4);
    check("rst_dout", dout, 0);
    check("rst_oe", dout_oe, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_addr", cur_addr, 0);
    rst = 1'b0;
    wait_clk(H);

    set_ch(0, 12'hABC);
    run_frame(3'd0);
    check("t1_word", cap, 16'h0ABC);
    check("t1_done_cnt", done_cnt, 1);

    set_ch(0, 12'h123);
    set_ch(5, 12'hFFF);
    run_frame(3'd5);
    check("t2_addr", cur_addr, 5);
    run_frame(3'd5);

    set_ch(2, 12'h555);
    set_ch(7, 12'h0F0);
    run_pair(3'd2, 3'd7);
    check("t3_done_cnt", done_cnt, exp_done);

    run_abort(3'd6, 9);
    check("t4_err_cnt", err_cnt, exp_err);
    check("t4_addr", cur_addr, 7);
    run_frame(3'd4);

    cs_low();
    frame_bits(3'd3, 1, 8);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    m_addr = 3'd0;
    for (int k = 0; k < 16; k++) begin
      sck_cycle(1'($urandom_range(0, 1)));
      check("t5_oe", dout_oe, 0);
    end
    check("t5_addr", cur_addr, 0);
    check("t5_done_cnt", done_cnt, exp_done);
    cs_high();
    run_frame(3'd4);

    set_ch(4, 12'h800);
    cs_low();
    expect_frame(3'd4);
    frame_bits(3'd4, 1, 8);
    set_ch(4, 12'h001);
    frame_bits(3'd4, 9, 16);
    cs_high();
    check("t6_word", cap, 16'h0800);
    run_frame(3'd1);
    check("t6_next_word", cap, 16'h0001);

    for (int i = 0; i < 24; i++) begin
      ch_data = {$urandom, $urandom, $urandom};
      a1 = 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 2) run_abort(a1, $urandom_range(1, 15));
      else if (sel < 4) run_pair(a1, a2);
      else run_frame(a1);
    end

    wait_clk(H);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_cnt", done_cnt, exp_done);
    check("final_err_cnt", err_cnt, exp_err);
    check("final_addr", cur_addr, m_addr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
